seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle restoring shift-subtract divider. It is the inverse of the board's accumulate (adder) datapath: repeated subtraction in place of repeated addition.
- Sits beside the accumulator on the DE-series board top level:
  - operands come from switches;
  - start comes from a debounced KEY;
  - quotient and remainder drive Seg7 instances;
  - status drives LEDR.
- One start/busy/done handshake per division.

Parameters:
- WIDTH, 8, operand and result width in bits; must be at least 2.

Ports:
- clock  input  1  single system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  WIDTH  numerator; latched on an accepted start.
- divisor  input  WIDTH  denominator; latched on an accepted start.
- sign_mode  input  1  1 = two's-complement operands. Only honoured when the optional feature is compiled in.
- busy  output  1  high while a division is in progress.
- done  output  1  one-cycle pulse; the results are valid from this cycle onward.
- quotient  output  WIDTH  registered quotient; held until the next accepted start.
- remainder  output  WIDTH  registered remainder; held until the next accepted start.
- div_zero  output  1  the last division had divisor == 0.
- overflow  output  1  the last signed division overflowed; 0 when the feature is absent.

Behaviour:
- Reset (asynchronous, while reset=0), regardless of state:
  - state goes to IDLE;
  - busy, done, quotient, remainder, div_zero and overflow all go to 0;
  - iteration counter goes to 0;
  - a division in progress is abandoned with no done pulse.
- States: IDLE and RUN.
- IDLE, start=1 at edge N, divisor != 0:
  - latch the operands;
  - partial remainder = 0; shift register = dividend;
  - counter = WIDTH;
  - clear div_zero and overflow;
  - go to RUN; busy=1 from edge N.
- IDLE, start=1 at edge N, divisor == 0:
  - stay in IDLE; no RUN cycles;
  - at edge N: quotient = all ones, remainder = dividend, div_zero=1, done=1 for one cycle.
- RUN, each edge performs one restoring step:
  - P = {P[WIDTH-2:0], Q[WIDTH-1]};
  - D = P - divisor, computed at WIDTH+1 bits;
  - if D is non-negative: P = D and shift 1 into Q; otherwise keep P and shift 0 into Q;
  - decrement the counter.
- RUN, step with counter == 1:
  - register quotient and remainder;
  - done=1 and busy=0 for the following cycle;
  - return to IDLE.
- Latency: start accepted at edge N gives done high after edge N+WIDTH (edge N+8 at default width).
- done is exactly a one-cycle pulse. It deasserts at the next edge unless a new divide-by-zero start completes at that same edge.
- start while busy=1 is ignored: not queued, operands not re-sampled.
- start in the same cycle as done=1 (state is IDLE) is accepted normally; the previous results remain visible until they are overwritten.
- Changes to operand inputs during RUN have no effect.
- Unsigned arithmetic, with dividend = quotient*divisor + remainder and remainder < divisor:
  - 0 / x gives quotient 0, remainder 0;
  - x / 1 gives quotient x, remainder 0;
  - x / x gives quotient 1, remainder 0.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined, sign_mode=1:
  - magnitudes are taken at start and the unsigned core runs unchanged;
  - on completion, the quotient is negated when the operand signs differ;
  - the remainder takes the sign of the dividend (truncating division).
- Defined, sign_mode=1, most-negative / -1 (e.g. 0x80 / 0xFF):
  - overflow=1, quotient = most-negative (0x80), remainder = 0;
  - same latency as a normal division.
- Defined, signed divide-by-zero: same results as the unsigned divide-by-zero case.
- Not defined:
  - sign_mode is ignored;
  - overflow is tied to 0;
  - no sign logic is synthesised.

Decomposition:
- Package seq_divider_pkg holds:
  - the default WIDTH constant;
  - the state encoding (IDLE, RUN);
  - the all-ones result constant;
  - the counter-width function.
- One natural sub-module, div_step: combinational single restoring step.
  - Inputs: P, Q, divisor.
  - Outputs: next P, next Q.
  - Instantiated once by the FSM.

Test Plan:
- Unsigned 200 / 7, start at edge N → done only after edge N+8; quotient=28 (0x1C), remainder=4, div_zero=0.
- 5 / 0 → done after edge N; quotient=0xFF, remainder=5, div_zero=1, busy never asserted.
- 255 / 1, with start pulsed again at edges N+3 and N+5 and operands changed during RUN → quotient=0xFF, remainder=0; exactly one done pulse.
- Start 100 / 9, then reset=0 at edge N+4 → all outputs 0 immediately, no done pulse. Then start 100 / 9 again → quotient=11, remainder=1.
- Back-to-back: start 50 / 6 accepted in the done cycle of the previous division → second done after 8 further edges; quotient=8, remainder=2.
- With SEQ_DIVIDER_SIGNED_EN and sign_mode=1:
  - -100 / 7 (0x9C / 0x07) → quotient=0xF2 (-14), remainder=0xFE (-2);
  - 0x80 / 0xFF → overflow=1, quotient=0x80, remainder=0.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// seq_divider shared package: default width, FSM encoding,
// all-ones result constant and counter-width helper.
package seq_divider_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Wide enough for any sane WIDTH; sliced by users.
    localparam logic [63:0] ALL_ONES = '1;

    // Bits needed to hold the iteration count 0..w.
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one combinational restoring shift-subtract step.
// Ports: p/q/d in -> p_n/q_n out (partial remainder, quotient shift reg).
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] p,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p_n,
    output logic [WIDTH-1:0] q_n
);

    logic [WIDTH-1:0] p_sh;
    logic [WIDTH:0]   diff;

    // P never reaches 2^(WIDTH-1) before the last shift,
    // so dropping P's MSB loses nothing.
    assign p_sh = {p[WIDTH-2:0], q[WIDTH-1]};
    assign diff = {1'b0, p_sh} - {1'b0, d};

    always_comb begin
        p_n = p_sh;
        q_n = {q[WIDTH-2:0], 1'b0};
        if (!diff[WIDTH]) begin
            p_n = diff[WIDTH-1:0];
            q_n = {q[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle restoring divider, start/busy/done handshake.
// Ports: clock, reset (async, active-low), start, dividend, divisor,
//   sign_mode -> busy, done (1-cycle pulse), quotient, remainder,
//   div_zero, overflow. Signed mode built with SEQ_DIVIDER_SIGNED_EN.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sign_mode,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero,
    output logic             overflow
);

    localparam int CW = cnt_w(WIDTH);
    localparam logic [WIDTH-1:0] ONES = ALL_ONES[WIDTH-1:0];

    state_t           state_q, state_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dv_q, dv_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             ov_q, ov_d;

    logic [WIDTH-1:0] p_n, q_n;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH-1:0] q_fix, r_fix;
    logic             ovf_st;
    logic             accept;

    assign accept = (state_q == IDLE) && start
                  && (divisor != '0);

    div_step #(.WIDTH(WIDTH)) u_step (
        .p   (p_q),
        .q   (q_q),
        .d   (dv_q),
        .p_n (p_n),
        .q_n (q_n)
    );

`ifdef SEQ_DIVIDER_SIGNED_EN
    localparam logic [WIDTH-1:0] MIN_NEG =
        {1'b1, {(WIDTH-1){1'b0}}};

    logic a_neg, b_neg;
    logic neg_q_q, neg_r_q;

    assign a_neg = sign_mode & dividend[WIDTH-1];
    assign b_neg = sign_mode & divisor[WIDTH-1];
    assign a_mag = a_neg ? (~dividend) + 1'b1 : dividend;
    assign b_mag = b_neg ? (~divisor) + 1'b1 : divisor;

    // MIN / -1: magnitude core yields MIN r0 with no
    // sign fix-up, so only the flag needs raising.
    assign ovf_st = a_neg && b_neg
                 && (dividend == MIN_NEG)
                 && (divisor == ONES);

    assign q_fix = neg_q_q ? (~q_n) + 1'b1 : q_n;
    assign r_fix = neg_r_q ? (~p_n) + 1'b1 : p_n;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept) begin
            neg_q_q <= a_neg ^ b_neg;
            neg_r_q <= a_neg;
        end
    end
`else
    logic unused_sign;

    assign unused_sign = sign_mode;
    assign a_mag  = dividend;
    assign b_mag  = divisor;
    assign ovf_st = 1'b0;
    assign q_fix  = q_n;
    assign r_fix  = p_n;
`endif

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dv_d    = dv_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;
        ov_d    = ov_q;
        unique case (state_q)
            IDLE: begin
                if (start && divisor == '0) begin
                    quo_d  = ONES;
                    rem_d  = dividend;
                    dz_d   = 1'b1;
                    ov_d   = 1'b0;
                    done_d = 1'b1;
                end else if (accept) begin
                    p_d     = '0;
                    q_d     = a_mag;
                    dv_d    = b_mag;
                    cnt_d   = CW'(WIDTH);
                    dz_d    = 1'b0;
                    ov_d    = ovf_st;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                p_d   = p_n;
                q_d   = q_n;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    quo_d   = q_fix;
                    rem_d   = r_fix;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dv_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dv_q    <= dv_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
            ov_q    <= ov_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign div_zero  = dz_q;
    assign overflow  = ov_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider: table-driven vectors plus hand-written
// multi-cycle sequences for seq_divider (WIDTH=8).
module tb_seq_divider;

    localparam int W = 8;

    logic         clock;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         sign_mode;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;
    logic         overflow;

    int n_assert;
    int n_fail;

    seq_divider #(.WIDTH(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .sign_mode (sign_mode),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero),
        .overflow  (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        logic         edz;
        logic         eov;
        int           lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h",
                     name, act, exp);
        end
    endtask

    task automatic add(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input logic sm,
                       input logic [W-1:0] eq,
                       input logic [W-1:0] er,
                       input logic edz,
                       input logic eov,
                       input int lat);
        vec_t v;
        v.a = a; v.b = b; v.sm = sm;
        v.eq = eq; v.er = er;
        v.edz = edz; v.eov = eov; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Pulse start for one edge; leaves time at edge N + 1.
    task automatic kick(input logic [W-1:0] a,
                        input logic [W-1:0] b,
                        input logic sm);
        @(negedge clock);
        dividend  = a;
        divisor   = b;
        sign_mode = sm;
        start     = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // Count edges after edge N until done, bounded.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(posedge clock);
            #1;
            cyc++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        string t;
        kick(v.a, v.b, v.sm);
        t = $sformatf("v%0d", idx);
        chk({t, " busy"}, busy, (v.lat != 0));
        wait_done(cyc);
        chk({t, " latency"}, cyc, v.lat);
        chk({t, " quotient"}, quotient, v.eq);
        chk({t, " remainder"}, remainder, v.er);
        chk({t, " div_zero"}, div_zero, v.edz);
        chk({t, " overflow"}, overflow, v.eov);
        @(posedge clock);
        #1;
        chk({t, " done pulse"}, done, 1'b0);
        chk({t, " busy idle"}, busy, 1'b0);
    endtask

    initial begin
        int cyc;
        int pulses;

        n_assert  = 0;
        n_fail    = 0;
        reset     = 1'b0;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        sign_mode = 1'b0;

        add(8'd200, 8'd7,   1'b0, 8'd28,  8'd4,  1'b0, 1'b0, 8);
        add(8'd5,   8'd0,   1'b0, 8'hFF,  8'd5,  1'b1, 1'b0, 0);
        add(8'd0,   8'd13,  1'b0, 8'd0,   8'd0,  1'b0, 1'b0, 8);
        add(8'd77,  8'd1,   1'b0, 8'd77,  8'd0,  1'b0, 1'b0, 8);
        add(8'd99,  8'd99,  1'b0, 8'd1,   8'd0,  1'b0, 1'b0, 8);
        add(8'd255, 8'd254, 1'b0, 8'd1,   8'd1,  1'b0, 1'b0, 8);
        add(8'd128, 8'd255, 1'b0, 8'd0,   8'd128,1'b0, 1'b0, 8);
        add(8'd3,   8'd200, 1'b0, 8'd0,   8'd3,  1'b0, 1'b0, 8);
        add(8'd254, 8'd2,   1'b0, 8'd127, 8'd0,  1'b0, 1'b0, 8);
`ifdef SEQ_DIVIDER_SIGNED_EN
        add(8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 8);
        add(8'h80, 8'hFF, 1'b1, 8'h80, 8'h00, 1'b0, 1'b1, 8);
        add(8'h64, 8'hF9, 1'b1, 8'hF2, 8'h02, 1'b0, 1'b0, 8);
        add(8'h9C, 8'h00, 1'b1, 8'hFF, 8'h9C, 1'b1, 1'b0, 0);
        add(8'h9C, 8'h07, 1'b0, 8'd22, 8'd2,  1'b0, 1'b0, 8);
`else
        add(8'h9C, 8'h07, 1'b1, 8'd22, 8'd2,  1'b0, 1'b0, 8);
        add(8'h80, 8'hFF, 1'b1, 8'd0,  8'h80, 1'b0, 1'b0, 8);
`endif

        repeat (2) @(posedge clock);
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst quotient", quotient, 8'd0);
        chk("rst remainder", remainder, 8'd0);
        chk("rst div_zero", div_zero, 1'b0);
        chk("rst overflow", overflow, 1'b0);
        @(negedge clock);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], i);

        // 255 / 1 with start re-pulsed and operands
        // changed while running.
        kick(8'd255, 8'd1, 1'b0);
        pulses = 0;
        for (int e = 1; e <= 14; e++) begin
            if (e == 3 || e == 5) begin
                dividend = 8'd17;
                divisor  = 8'd3;
                start    = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clock);
            #1;
            if (done) begin
                pulses++;
                chk("ign done edge", e, 8);
                chk("ign quotient", quotient, 8'hFF);
                chk("ign remainder", remainder, 8'd0);
            end
        end
        start = 1'b0;
        chk("ign pulses", pulses, 1);

        // Reset mid-division abandons it silently.
        kick(8'd100, 8'd9, 1'b0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        #1;
        chk("mid rst busy", busy, 1'b0);
        chk("mid rst quotient", quotient, 8'd0);
        chk("mid rst remainder", remainder, 8'd0);
        chk("mid rst div_zero", div_zero, 1'b0);
        pulses = 0;
        for (int e = 0; e < 12; e++) begin
            if (e == 2) reset = 1'b1;
            @(posedge clock);
            #1;
            if (done) pulses++;
        end
        chk("mid rst no done", pulses, 0);
        kick(8'd100, 8'd9, 1'b0);
        wait_done(cyc);
        chk("rerun latency", cyc, 8);
        chk("rerun quotient", quotient, 8'd11);
        chk("rerun remainder", remainder, 8'd1);

        // Back-to-back: next start in the done cycle.
        @(posedge clock);
        kick(8'd200, 8'd7, 1'b0);
        wait_done(cyc);
        chk("b2b first latency", cyc, 8);
        dividend = 8'd50;
        divisor  = 8'd6;
        start    = 1'b1;
        chk("b2b held quotient", quotient, 8'd28);
        @(posedge clock);
        #1;
        start = 1'b0;
        chk("b2b busy", busy, 1'b1);
        chk("b2b done low", done, 1'b0);
        chk("b2b old quotient", quotient, 8'd28);
        wait_done(cyc);
        chk("b2b second latency", cyc, 8);
        chk("b2b quotient", quotient, 8'd8);
        chk("b2b remainder", remainder, 8'd2);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
